// File: rtl/ext_io_bank.sv
// Host register bank: KEY/PT/user words, read-only CT and STAT, plus crypto core launch/timing FSM.
// Reads are registered (1 cycle); host writes to KEY/PT and run requests are refused while busy.
module ext_io_bank #(
  parameter int DATA_W  = 128,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              swrst,
  input  logic              run,
  input  logic              extin_en,
  input  logic [7:0]        extin_addr,
  input  logic [DATA_W-1:0] extin_data,
  input  logic [7:0]        extout_addr,
  output logic [DATA_W-1:0] extout_data,
  output logic [DATA_W-1:0] core_key,
  output logic [DATA_W-1:0] core_pt,
  output logic              core_start,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_ct,
  output logic              busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT
  } state_t;

  state_t            state;
  logic [31:0]       cnt;
  logic              done_flag;
  logic              tout_flag;
  logic              err_flag;
  logic [DATA_W-1:0] ct_word;
  logic [DATA_W-1:0] stat_word;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] mem [DEPTH];

  logic wr_in_range;
  logic rd_in_range;
  logic wr_ro;
  logic wr_keypt;
  logic wr_ok;
  logic wr_err;
  logic run_err;

  assign wr_in_range = ({1'b0, extin_addr} < 9'(DEPTH));
  assign rd_in_range = ({1'b0, extout_addr} < 9'(DEPTH));
  assign wr_ro       = (extin_addr == 8'd2) || (extin_addr == 8'd3);
  assign wr_keypt    = (extin_addr == 8'd0) || (extin_addr == 8'd1);
  assign wr_ok       = extin_en && wr_in_range && !wr_ro && !(wr_keypt && busy);
  assign wr_err      = extin_en && wr_in_range && (wr_ro || (wr_keypt && busy));
  assign run_err     = run && (state != S_IDLE);

  assign core_key = mem[0];
  assign core_pt  = mem[1];

  always_comb begin
    stat_word       = '0;
    stat_word[31:0] = cnt;
    stat_word[32]   = done_flag;
    stat_word[33]   = tout_flag;
    stat_word[34]   = err_flag;
  end

  // Slots 2/3 of mem are never written; CT and STAT are served from dedicated registers.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      if (extout_addr == 8'd2) begin
        rd_word = ct_word;
      end else if (extout_addr == 8'd3) begin
        rd_word = stat_word;
      end else begin
        rd_word = mem[extout_addr[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (swrst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      mem[extin_addr[AW-1:0]] <= extin_data;
    end
  end

  // Non-blocking update means a same-cycle write to the read address returns the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      extout_data <= '0;
    end else if (swrst) begin
      extout_data <= '0;
    end else begin
      extout_data <= rd_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      core_start <= 1'b0;
      cnt        <= '0;
      done_flag  <= 1'b0;
      tout_flag  <= 1'b0;
      err_flag   <= 1'b0;
      ct_word    <= '0;
    end else if (swrst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      core_start <= 1'b0;
      cnt        <= '0;
      done_flag  <= 1'b0;
      tout_flag  <= 1'b0;
      err_flag   <= 1'b0;
      ct_word    <= '0;
    end else begin
      core_start <= 1'b0;
      if (wr_err || run_err) begin
        err_flag <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (run) begin
            state      <= S_LAUNCH;
            busy       <= 1'b1;
            core_start <= 1'b1;
            done_flag  <= 1'b0;
            tout_flag  <= 1'b0;
            cnt        <= '0;
          end
        end
        S_LAUNCH: begin
          state <= S_WAIT;
          cnt   <= 32'd1;
        end
        S_WAIT: begin
          // The count includes the completing cycle, so it advances on every WAIT cycle.
          if (cnt != 32'hFFFF_FFFF) begin
            cnt <= cnt + 32'd1;
          end
          if (core_done) begin
            ct_word   <= core_ct;
            done_flag <= 1'b1;
            state     <= S_IDLE;
            busy      <= 1'b0;
          end else if (cnt == 32'(TIMEOUT)) begin
            tout_flag <= 1'b1;
            state     <= S_IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ext_io_bank.sv
// Directed bench for ext_io_bank: table of write/read vectors plus run, protection,
// timeout, software reset and asynchronous reset sequences.
module tb_ext_io_bank;

  localparam int DW = 128;

  logic          clk;
  logic          rst_n;
  logic          swrst;
  logic          run;
  logic          extin_en;
  logic [7:0]    extin_addr;
  logic [DW-1:0] extin_data;
  logic [7:0]    extout_addr;
  logic [DW-1:0] extout_data;
  logic [DW-1:0] core_key;
  logic [DW-1:0] core_pt;
  logic          core_start;
  logic          core_done;
  logic [DW-1:0] core_ct;
  logic          busy;

  int n_checks;
  int n_fails;
  int n_starts;
  int busy_cycles;

  localparam logic [DW-1:0] KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [DW-1:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [DW-1:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [DW-1:0] WA   = 128'hdeadbeef_00000001_cafef00d_12345678;
  localparam logic [DW-1:0] WB   = 128'h0f0f0f0f_f0f0f0f0_55555555_aaaaaaaa;
  localparam logic [DW-1:0] WC   = 128'h11111111_22222222_33333333_44444444;
  localparam logic [DW-1:0] WX   = 128'hffffffff_ffffffff_ffffffff_ffffffff;
  localparam logic [DW-1:0] EST  = 128'h4_0000_0000;
  localparam logic [DW-1:0] DST  = 128'h1_0000_000b;

  ext_io_bank #(.DATA_W(DW), .DEPTH(16), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .swrst(swrst), .run(run),
    .extin_en(extin_en), .extin_addr(extin_addr), .extin_data(extin_data),
    .extout_addr(extout_addr), .extout_data(extout_data),
    .core_key(core_key), .core_pt(core_pt), .core_start(core_start),
    .core_done(core_done), .core_ct(core_ct), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          en;
    logic [7:0]    waddr;
    logic [DW-1:0] wdata;
    logic [7:0]    raddr;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (core_start === 1'b1) n_starts++;
  endtask

  task automatic wr(input logic [7:0] a, input logic [DW-1:0] d);
    extin_en = 1'b1; extin_addr = a; extin_data = d;
    tick();
    extin_en = 1'b0;
  endtask

  task automatic rd(input string name, input logic [7:0] a, input logic [DW-1:0] exp);
    extout_addr = a;
    tick();
    check(name, extout_data, exp);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 8'd5,   WA, 8'd5,   '0};
    vecs[1]  = '{1'b0, 8'd0,   '0, 8'd5,   WA};
    vecs[2]  = '{1'b1, 8'd200, WX, 8'd200, '0};
    vecs[3]  = '{1'b0, 8'd0,   '0, 8'd3,   '0};
    vecs[4]  = '{1'b1, 8'd4,   WB, 8'd4,   '0};
    vecs[5]  = '{1'b0, 8'd0,   '0, 8'd4,   WB};
    vecs[6]  = '{1'b1, 8'd2,   WX, 8'd2,   '0};
    vecs[7]  = '{1'b0, 8'd0,   '0, 8'd3,   EST};
    vecs[8]  = '{1'b1, 8'd15,  WC, 8'd5,   WA};
    vecs[9]  = '{1'b1, 8'd16,  WX, 8'd15,  WC};
    vecs[10] = '{1'b0, 8'd0,   '0, 8'd16,  '0};
    vecs[11] = '{1'b1, 8'd3,   WX, 8'd3,   EST};
    vecs[12] = '{1'b0, 8'd0,   '0, 8'd2,   '0};

    n_checks = 0; n_fails = 0; n_starts = 0;
    rst_n = 1'b0; swrst = 1'b0; run = 1'b0; extin_en = 1'b0;
    extin_addr = '0; extin_data = '0; extout_addr = '0;
    core_done = 1'b0; core_ct = '0;
    #23;
    check("reset_extout", extout_data, '0);
    check("reset_busy", {127'd0, busy}, '0);
    check("reset_start", {127'd0, core_start}, '0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) begin
      extin_en = vecs[i].en; extin_addr = vecs[i].waddr; extin_data = vecs[i].wdata;
      extout_addr = vecs[i].raddr;
      tick();
      check($sformatf("vec%0d", i), extout_data, vecs[i].exp);
    end
    extin_en = 1'b0;

    swrst = 1'b1; tick(); swrst = 1'b0;
    rd("swrst_word5", 8'd5, '0);
    rd("swrst_stat", 8'd3, '0);

    // Normal run: done arrives 10 cycles after the start cycle.
    wr(8'd0, KEY);
    wr(8'd1, PT);
    check("core_key", core_key, KEY);
    check("core_pt", core_pt, PT);
    n_starts = 0;
    run = 1'b1; tick(); run = 1'b0;
    check("run_start", {127'd0, core_start}, 128'd1);
    check("run_busy", {127'd0, busy}, 128'd1);
    for (int i = 0; i < 10; i++) tick();
    core_done = 1'b1; core_ct = CT;
    tick();
    core_done = 1'b0; core_ct = '0;
    check("run_busy_drop", {127'd0, busy}, '0);
    check("run_one_start", 128'(n_starts), 128'd1);
    rd("run_ct", 8'd2, CT);
    rd("run_stat", 8'd3, DST);

    // Protection and timeout: refused writes and run during busy, core never completes.
    n_starts = 0;
    run = 1'b1; tick(); run = 1'b0;
    busy_cycles = 1;
    wr(8'd1, WX); busy_cycles++;
    wr(8'd2, WX); busy_cycles++;
    run = 1'b1; tick(); run = 1'b0; busy_cycles++;
    while (busy === 1'b1 && busy_cycles < 200) begin
      tick();
      if (busy === 1'b1) busy_cycles++;
    end
    check("tout_busy_cycles", 128'(busy_cycles), 128'd17);
    check("prot_one_start", 128'(n_starts), 128'd1);
    check("prot_pt", core_pt, PT);
    rd("prot_pt_read", 8'd1, PT);
    rd("tout_ct_kept", 8'd2, CT);
    extout_addr = 8'd3; tick();
    check("tout_stat_flags", {125'd0, extout_data[34:32]}, 128'd6);

    // Completion pulse while idle is ignored.
    core_done = 1'b1; core_ct = WX; tick(); core_done = 1'b0;
    rd("idle_done_ct", 8'd2, CT);

    // Software reset mid-run, then a late completion.
    run = 1'b1; tick(); run = 1'b0;
    tick(); tick(); tick();
    swrst = 1'b1; tick(); swrst = 1'b0;
    check("swrst_busy", {127'd0, busy}, '0);
    core_done = 1'b1; core_ct = CT; tick(); core_done = 1'b0;
    rd("swrst_ct", 8'd2, '0);
    rd("swrst_key", 8'd0, '0);
    rd("swrst_stat2", 8'd3, '0);
    check("swrst_core_key", core_key, '0);

    // Asynchronous reset while the launch pulse is high.
    wr(8'd5, WA);
    wr(8'd0, KEY);
    extout_addr = 8'd5;
    run = 1'b1; tick(); run = 1'b0;
    check("pre_arst_start", {127'd0, core_start}, 128'd1);
    check("pre_arst_read", extout_data, WA);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {127'd0, busy}, '0);
    check("arst_start", {127'd0, core_start}, '0);
    check("arst_extout", extout_data, '0);
    #2 rst_n = 1'b1;
    rd("arst_word5", 8'd5, '0);
    rd("arst_key", 8'd0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
